// File: rtl/systolic_pkg.sv
// Shared types and index helpers for the output-stationary systolic matrix multiplier.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Drain counter must hold 0 .. 2N-1.
    function automatic int drain_cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(2 * n);
    endfunction

    function automatic int op_lo(input int slot, input int data_w);
        return slot * data_w;
    endfunction

    function automatic int pe_bit(input int i, input int j, input int n);
        return i * n + j;
    endfunction

    function automatic int pe_lo(input int i, input int j, input int n, input int acc_w);
        return (i * n + j) * acc_w;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: forwards a rightward and b downward with their tags,
// accumulates a*b when both tags are valid, and keeps a sticky overflow flag.
module systolic_pe #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_v_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              b_v_in,
    output logic [DATA_W-1:0] a_out,
    output logic              a_v_out,
    output logic [DATA_W-1:0] b_out,
    output logic              b_v_out,
    output logic [ACC_W-1:0]  acc,
    output logic              ovf
);

    localparam bit SGN = (SIGNED != 0);

    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] b_ext;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W:0]   wide_sum;
    logic             add_ovf;

    // Operands are extended to ACC_W before multiplying; since ACC_W >= 2*DATA_W the
    // low ACC_W bits equal the full product already sign/zero-extended.
    always_comb begin
        a_ext    = {{(ACC_W-DATA_W){SGN & a_in[DATA_W-1]}}, a_in};
        b_ext    = {{(ACC_W-DATA_W){SGN & b_in[DATA_W-1]}}, b_in};
        prod_ext = a_ext * b_ext;
        wide_sum = {1'b0, acc} + {1'b0, prod_ext};
        if (SGN) begin
            add_ovf = (acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (wide_sum[ACC_W-1] != acc[ACC_W-1]);
        end else begin
            add_ovf = wide_sum[ACC_W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_out   <= '0;
            a_v_out <= 1'b0;
            b_out   <= '0;
            b_v_out <= 1'b0;
            acc     <= '0;
            ovf     <= 1'b0;
        end else begin
            a_out   <= a_in;
            a_v_out <= a_v_in;
            b_out   <= b_in;
            b_v_out <= b_v_in;
            if (clr) begin
                acc <= '0;
                ovf <= 1'b0;
            end else if (a_v_in && b_v_in) begin
                acc <= wide_sum[ACC_W-1:0];
                ovf <= ovf | add_ovf;
            end
        end
    end

endmodule

// File: rtl/systolic_nxn.sv
// NxN output-stationary systolic multiplier C = A*B: job FSM, drain counter,
// operand skew lines and the PE grid with flattened result/overflow outputs.
module systolic_nxn
    import systolic_pkg::*;
#(
    parameter int N      = 2,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64,
    parameter int SIGNED = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  accum_en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [N*DATA_W-1:0]   row_in,
    input  logic [N*DATA_W-1:0]   col_in,
    output logic [N*N*ACC_W-1:0]  result,
    output logic [N*N-1:0]        ovf,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dbg_state
);

    localparam int               CNT_W    = drain_cnt_w(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * N - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] drain_cnt;
    logic             beat_acc;
    logic             job_clr;

    // Handshake: a beat transfers on a rising edge where in_valid && in_ready; in_ready
    // depends only on state, and an offered beat is held by the source until it transfers.
    assign beat_acc  = in_valid & in_ready;
    assign job_clr   = beat_acc & (state == IDLE) & ~accum_en;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = in_last ? DRAIN : FEED;
                end
            end
            FEED: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && in_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The last PE takes its final product 2N-1 edges after the last beat; one more edge
    // lands in DONE so results are settled for the whole done cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain_cnt <= '0;
        end else if (state == DRAIN && drain_cnt != CNT_LAST) begin
            drain_cnt <= drain_cnt + 1'b1;
        end else begin
            drain_cnt <= '0;
        end
    end

    logic [DATA_W-1:0] a_bus [N][N+1];
    logic              a_vb  [N][N+1];
    logic [DATA_W-1:0] b_bus [N+1][N];
    logic              b_vb  [N+1][N];

    // Row slot i passes through stage 0 plus i extra registers before entering column 0.
    for (genvar gi = 0; gi < N; gi++) begin : g_row_skew
        logic [DATA_W-1:0] sr_d [gi+1];
        logic [gi:0]       sr_v;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int d = 0; d <= gi; d++) begin
                    sr_d[d] <= '0;
                end
                sr_v <= '0;
            end else begin
                sr_d[0] <= row_in[op_lo(gi, DATA_W) +: DATA_W];
                sr_v[0] <= beat_acc;
                for (int d = 1; d <= gi; d++) begin
                    sr_d[d] <= sr_d[d-1];
                    sr_v[d] <= sr_v[d-1];
                end
            end
        end

        assign a_bus[gi][0] = sr_d[gi];
        assign a_vb[gi][0]  = sr_v[gi];
    end

    for (genvar gj = 0; gj < N; gj++) begin : g_col_skew
        logic [DATA_W-1:0] sr_d [gj+1];
        logic [gj:0]       sr_v;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int d = 0; d <= gj; d++) begin
                    sr_d[d] <= '0;
                end
                sr_v <= '0;
            end else begin
                sr_d[0] <= col_in[op_lo(gj, DATA_W) +: DATA_W];
                sr_v[0] <= beat_acc;
                for (int d = 1; d <= gj; d++) begin
                    sr_d[d] <= sr_d[d-1];
                    sr_v[d] <= sr_v[d-1];
                end
            end
        end

        assign b_bus[0][gj] = sr_d[gj];
        assign b_vb[0][gj]  = sr_v[gj];
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_pe_row
        for (genvar gj = 0; gj < N; gj++) begin : g_pe_col
            systolic_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W),
                .SIGNED (SIGNED)
            ) u_pe (
                .clk     (clk),
                .rst     (rst),
                .clr     (job_clr),
                .a_in    (a_bus[gi][gj]),
                .a_v_in  (a_vb[gi][gj]),
                .b_in    (b_bus[gi][gj]),
                .b_v_in  (b_vb[gi][gj]),
                .a_out   (a_bus[gi][gj+1]),
                .a_v_out (a_vb[gi][gj+1]),
                .b_out   (b_bus[gi+1][gj]),
                .b_v_out (b_vb[gi+1][gj]),
                .acc     (result[pe_lo(gi, gj, N, ACC_W) +: ACC_W]),
                .ovf     (ovf[pe_bit(gi, gj, N)])
            );
        end
    end

endmodule

// File: tb/tb_systolic_nxn.sv
// Self-checking bench for systolic_nxn: a signed 2x2 instance driven from a matrix
// model with a result scoreboard, plus an unsigned 4x4 instance for the identity case.
module tb_systolic_nxn;

    localparam int N   = 2;
    localparam int DW  = 32;
    localparam int AW  = 64;
    localparam int N4  = 4;
    localparam int RW  = N * N * AW + N * N;
    localparam int RW4 = N4 * N4 * AW + N4 * N4;

    logic clk;
    logic rst;

    logic                accum_en, in_valid, in_ready, in_last, busy, done;
    logic [N*DW-1:0]     row_in, col_in;
    logic [N*N*AW-1:0]   result;
    logic [N*N-1:0]      ovf;
    logic [1:0]          dbg_state;

    logic                accum_en_4, in_valid_4, in_ready_4, in_last_4, busy_4, done_4;
    logic [N4*DW-1:0]    row_in_4, col_in_4;
    logic [N4*N4*AW-1:0] result_4;
    logic [N4*N4-1:0]    ovf_4;
    logic [1:0]          dbg_state_4;

    int checks;
    int failures;

    logic [RW-1:0]  exp_q[$];
    logic [RW4-1:0] exp4_q[$];

    logic [AW-1:0] mdl_c   [N][N];
    bit            mdl_ovf [N][N];
    logic [DW-1:0] a_m     [N][16];
    logic [DW-1:0] b_m     [16][N];

    systolic_nxn #(.N(N), .DATA_W(DW), .ACC_W(AW), .SIGNED(1)) dut (
        .clk(clk), .rst(rst), .accum_en(accum_en), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last), .row_in(row_in), .col_in(col_in),
        .result(result), .ovf(ovf), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    systolic_nxn #(.N(N4), .DATA_W(DW), .ACC_W(AW), .SIGNED(0)) dut4 (
        .clk(clk), .rst(rst), .accum_en(accum_en_4), .in_valid(in_valid_4),
        .in_ready(in_ready_4), .in_last(in_last_4), .row_in(row_in_4), .col_in(col_in_4),
        .result(result_4), .ovf(ovf_4), .busy(busy_4), .done(done_4), .dbg_state(dbg_state_4)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic void model_clear();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                mdl_c[i][j]   = '0;
                mdl_ovf[i][j] = 1'b0;
            end
    endfunction

    function automatic void model_beat(input int k);
        logic signed [63:0] p;
        logic signed [65:0] ex;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                p  = $signed(a_m[i][k]) * $signed(b_m[k][j]);
                ex = $signed(mdl_c[i][j]) + p;
                mdl_c[i][j] = ex[63:0];
                if (ex[65:63] != 3'b000 && ex[65:63] != 3'b111) mdl_ovf[i][j] = 1'b1;
            end
    endfunction

    function automatic logic [RW-1:0] pack_exp();
        logic [RW-1:0] e;
        e = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                e[(i*N+j)*AW +: AW] = mdl_c[i][j];
                e[N*N*AW + i*N + j] = mdl_ovf[i][j];
            end
        return e;
    endfunction

    function automatic void fill_const(input logic [DW-1:0] av, input logic [DW-1:0] bv, input int kk);
        for (int k = 0; k < kk; k++)
            for (int s = 0; s < N; s++) begin
                a_m[s][k] = av;
                b_m[k][s] = bv;
            end
    endfunction

    function automatic void fill_t1();
        a_m[0][0] = 32'd1; a_m[0][1] = 32'd2; a_m[1][0] = 32'd3; a_m[1][1] = 32'd4;
        b_m[0][0] = 32'd5; b_m[0][1] = 32'd6; b_m[1][0] = 32'd7; b_m[1][1] = 32'd8;
    endfunction

    // ---------------- driver ----------------
    task automatic send_job(input int kk, input bit accum, input int gap);
        int t;
        for (int k = 0; k < kk; k++) begin
            if (k > 0) begin
                repeat (gap) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_last  = (k == kk - 1);
            accum_en = (k == 0) ? accum : ~accum;
            for (int s = 0; s < N; s++) begin
                row_in[s*DW +: DW] = a_m[s][k];
                col_in[s*DW +: DW] = b_m[k][s];
            end
            t = 0;
            while (!in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                checks++;
                failures++;
                $display("FAIL beat_accept: in_ready=%0b required=1 (beat %0d)", in_ready, k);
            end
            @(posedge clk);
            if (k == 0 && !accum) model_clear();
            model_beat(k);
        end
        exp_q.push_back(pack_exp());
    endtask

    // Waits for done after the last beat; hold keeps junk beats offered through drain.
    task automatic wait_done(input int exp_edges, input bit hold, input string name);
        int edges;
        int rdy_bad;
        bit got;
        logic [RW-1:0] e;
        edges = 0; rdy_bad = 0; got = 1'b0;
        @(negedge clk);
        if (hold) begin
            in_valid = 1'b1;
            in_last  = 1'b1;
            for (int s = 0; s < N; s++) begin
                row_in[s*DW +: DW] = $urandom;
                col_in[s*DW +: DW] = $urandom;
            end
        end else begin
            in_valid = 1'b0;
        end
        if (in_ready) rdy_bad++;
        while (!got && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (in_ready) rdy_bad++;
            if (done) got = 1'b1;
        end
        in_valid = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s_done_timeout: done never seen in %0d edges", name, edges);
        end else if (edges != exp_edges) begin
            failures++;
            $display("FAIL %s_latency: got %0d edges required %0d", name, edges, exp_edges);
        end
        checks++;
        if (rdy_bad != 0) begin
            failures++;
            $display("FAIL %s_ready_in_drain: in_ready high %0d cycles required 0", name, rdy_bad);
        end
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s_scoreboard: no expected entry queued", name);
            e = '0;
        end else begin
            e = exp_q.pop_front();
            if (result !== e[N*N*AW-1:0]) begin
                failures++;
                $display("FAIL %s_result: got %h required %h", name, result, e[N*N*AW-1:0]);
            end
            checks++;
            if (ovf !== e[RW-1:N*N*AW]) begin
                failures++;
                $display("FAIL %s_ovf: got %b required %b", name, ovf, e[RW-1:N*N*AW]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL %s_after_done: done=%b busy=%b state=%0d required 0 0 0", name, done, busy, dbg_state);
        end
        checks++;
        if (result !== e[N*N*AW-1:0]) begin
            failures++;
            $display("FAIL %s_result_stable: got %h required %h", name, result, e[N*N*AW-1:0]);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: in_ready=%b busy=%b done=%b required 1 0 0", in_ready, busy, done);
        end
        checks++;
        if (result !== '0 || ovf !== '0) begin
            failures++;
            $display("FAIL reset_data: result=%h ovf=%b required 0", result, ovf);
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_state: got %0d required 0", dbg_state);
        end
        checks++;
        if (in_ready_4 !== 1'b1 || busy_4 !== 1'b0 || done_4 !== 1'b0 || result_4 !== '0 || ovf_4 !== '0) begin
            failures++;
            $display("FAIL reset_n4: in_ready=%b busy=%b done=%b ovf=%h required 1 0 0 0", in_ready_4, busy_4, done_4, ovf_4);
        end
    endtask

    task automatic test_basic();
        fill_t1();
        send_job(2, 1'b0, 0);
        wait_done(4, 1'b0, "basic");
        checks++;
        if (result[0 +: AW] !== 64'd19 || result[3*AW +: AW] !== 64'd50) begin
            failures++;
            $display("FAIL basic_const: c00=%0d c11=%0d required 19 50", result[0 +: AW], result[3*AW +: AW]);
        end
    endtask

    task automatic test_accum();
        fill_t1();
        send_job(2, 1'b1, 0);
        wait_done(4, 1'b0, "accum");
        checks++;
        if (result[3*AW +: AW] !== 64'd100 || result[2*AW +: AW] !== 64'd86) begin
            failures++;
            $display("FAIL accum_const: c10=%0d c11=%0d required 86 100", result[2*AW +: AW], result[3*AW +: AW]);
        end
        fill_const(32'd2, 32'd2, 1);
        send_job(1, 1'b0, 0);
        wait_done(4, 1'b0, "k1_clear");
        checks++;
        if (result[AW +: AW] !== 64'd4) begin
            failures++;
            $display("FAIL k1_const: c01=%0d required 4", result[AW +: AW]);
        end
    endtask

    task automatic test_gaps();
        fill_t1();
        send_job(2, 1'b0, 2);
        wait_done(4, 1'b1, "gaps_hold");
    endtask

    task automatic test_overflow();
        fill_const(32'h8000_0000, 32'h8000_0000, 3);
        send_job(2, 1'b0, 0);
        wait_done(4, 1'b0, "ovf_k2");
        checks++;
        if (result[0 +: AW] !== 64'h8000_0000_0000_0000 || ovf[0] !== 1'b1) begin
            failures++;
            $display("FAIL ovf_const: c00=%h ovf0=%b required 8000000000000000 1", result[0 +: AW], ovf[0]);
        end
        send_job(3, 1'b0, 0);
        wait_done(4, 1'b0, "ovf_k3");
        fill_const(32'd1, 32'd1, 1);
        send_job(1, 1'b0, 0);
        wait_done(4, 1'b0, "ovf_clear");
        checks++;
        if (ovf !== 4'b0000) begin
            failures++;
            $display("FAIL ovf_cleared: got %b required 0000", ovf);
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        logic [RW-1:0] drop;
        fill_t1();
        send_job(2, 1'b0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (dbg_state !== 2'd2) begin
            failures++;
            $display("FAIL mid_in_drain: state=%0d required 2", dbg_state);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (result !== '0 || ovf !== '0 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_async_clear: result=%h busy=%b done=%b in_ready=%b required 0 0 0 1", result, busy, done, in_ready);
        end
        drop = exp_q.pop_back();
        model_clear();
        saw_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL mid_no_done: done pulsed after abort, required none");
        end
        fill_const(32'd3, 32'd3, 1);
        send_job(1, 1'b0, 0);
        wait_done(4, 1'b0, "after_abort");
        checks++;
        if (result[2*AW +: AW] !== 64'd9) begin
            failures++;
            $display("FAIL after_abort_const: c10=%0d required 9", result[2*AW +: AW]);
        end
    endtask

    task automatic test_random();
        int kk;
        for (int n = 0; n < 6; n++) begin
            kk = $urandom_range(1, 4);
            for (int k = 0; k < kk; k++)
                for (int s = 0; s < N; s++) begin
                    a_m[s][k] = $urandom;
                    b_m[k][s] = $urandom;
                end
            send_job(kk, 1'($urandom_range(0, 1)), $urandom_range(0, 1));
            wait_done(4, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_n4();
        logic [RW4-1:0] e;
        logic [63:0] s;
        int edges;
        bit got;
        e = '0;
        for (int i = 0; i < N4; i++)
            for (int j = 0; j < N4; j++) begin
                s = '0;
                for (int k = 0; k < N4; k++) s += ((i == k) ? 64'd1 : 64'd0) * 64'(k * 4 + j);
                e[(i*N4+j)*AW +: AW] = s;
            end
        exp4_q.push_back(e);
        for (int k = 0; k < N4; k++) begin
            @(negedge clk);
            in_valid_4 = 1'b1;
            in_last_4  = (k == N4 - 1);
            accum_en_4 = 1'b0;
            for (int q = 0; q < N4; q++) begin
                row_in_4[q*DW +: DW] = (q == k) ? 32'd1 : 32'd0;
                col_in_4[q*DW +: DW] = 32'(k * 4 + q);
            end
            if (!in_ready_4) begin
                checks++;
                failures++;
                $display("FAIL n4_accept: in_ready=0 required 1 (beat %0d)", k);
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid_4 = 1'b0;
        edges = 0; got = 1'b0;
        while (!got && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done_4) got = 1'b1;
        end
        checks++;
        if (!got || edges != 8) begin
            failures++;
            $display("FAIL n4_latency: got %0d edges (done seen=%b) required 8", edges, got);
        end
        e = exp4_q.pop_front();
        checks++;
        if (result_4 !== e[N4*N4*AW-1:0]) begin
            failures++;
            $display("FAIL n4_result: c32=%0d c33=%0d required %0d %0d", result_4[14*AW +: AW], result_4[15*AW +: AW], e[14*AW +: AW], e[15*AW +: AW]);
        end
        checks++;
        if (ovf_4 !== e[RW4-1:N4*N4*AW] || result_4[14*AW +: AW] !== 64'd14) begin
            failures++;
            $display("FAIL n4_ovf_const: ovf=%h c32=%0d required 0 14", ovf_4, result_4[14*AW +: AW]);
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        checks = 0; failures = 0;
        rst = 1'b0;
        accum_en = 1'b0; in_valid = 1'b0; in_last = 1'b0; row_in = '0; col_in = '0;
        accum_en_4 = 1'b0; in_valid_4 = 1'b0; in_last_4 = 1'b0; row_in_4 = '0; col_in_4 = '0;
        model_clear();
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        @(negedge clk);
        test_basic();
        test_accum();
        test_gaps();
        test_overflow();
        test_reset_mid();
        test_random();
        test_n4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
